// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and the receive-FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef struct packed {
        logic                      frame_err;
        logic                      parity_err;
        logic [UART_DATA_BITS-1:0] data;
    } rx_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Generic first-word-fall-through FIFO with push/pop/flush.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign w_do_pop  = pop & ~empty;
    // When full, a concurrent pop frees the slot the write pointer already aims at.
    assign w_do_push = push & (~full | w_do_pop);
    assign rdata     = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receive buffer: captures frames on data_ready rising
//               edge into a FWFT FIFO, tracks overrun. Optional watermark
//               interrupt enabled by UART_RX_FIFO_WATERMARK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DEPTH     = 16,
    parameter int WATERMARK = 12
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [DATA_BITS-1:0]   rx_data,
    input  logic                   data_ready,
    input  logic                   parity_err,
    input  logic                   frame_err,
    input  logic                   flush,
    input  logic                   clear_overrun,
    output logic [DATA_BITS-1:0]   m_data,
    output logic                   m_parity_err,
    output logic                   m_frame_err,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overrun,
    output logic                   level_irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (DATA_BITS != UART_DATA_BITS) begin : g_bad_width
        $fatal(1, "uart_rx_fifo: DATA_BITS must match uart_pkg::UART_DATA_BITS");
    end

    logic      dr_q;
    logic      overrun_q;
    logic      w_push;
    logic      w_pop;
    logic      w_empty;
    rx_entry_t w_wr_entry;
    rx_entry_t w_rd_entry;

    assign w_push     = data_ready & ~dr_q;
    assign w_pop      = m_valid & m_ready;
    assign w_wr_entry = '{frame_err: frame_err, parity_err: parity_err, data: rx_data};

    sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_push),
        .pop    (w_pop),
        .flush  (flush),
        .wdata  (w_wr_entry),
        .rdata  (w_rd_entry),
        .count  (count),
        .full   (full),
        .empty  (w_empty)
    );

    assign m_valid      = ~w_empty;
    assign m_data       = w_rd_entry.data;
    assign m_parity_err = w_rd_entry.parity_err;
    assign m_frame_err  = w_rd_entry.frame_err;
    assign overrun      = overrun_q;

    // dr_q survives flush so a frame still in progress is not captured twice.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dr_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            dr_q <= data_ready;
            if (flush)
                overrun_q <= 1'b0;
            else if (w_push && full && !w_pop)
                overrun_q <= 1'b1;
            else if (clear_overrun)
                overrun_q <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_WATERMARK_EN
    if (WATERMARK < 1 || WATERMARK > DEPTH) begin : g_bad_watermark
        $fatal(1, "uart_rx_fifo: WATERMARK must be in 1..DEPTH");
    end

    logic          level_irq_q;
    logic          w_push_ok;
    logic [CW-1:0] w_count_d;

    // Next fill level, so the interrupt changes on the same edge as count.
    assign w_push_ok = w_push & (~full | w_pop);
    assign w_count_d = flush ? '0 : count + CW'(w_push_ok) - CW'(w_pop);
    assign level_irq = level_irq_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            level_irq_q <= 1'b0;
        else
            level_irq_q <= (w_count_d >= CW'(WATERMARK));
    end
`else
    assign level_irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rx_data = '0;
    logic       data_ready = 1'b0;
    logic       parity_err = 1'b0;
    logic       frame_err = 1'b0;
    logic       flush = 1'b0;
    logic       clear_overrun = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_parity_err;
    logic       m_frame_err;
    logic       m_valid;
    logic [4:0] count;
    logic       full;
    logic       overrun;
    logic       level_irq;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_fifo #(.DATA_BITS(8), .DEPTH(DEPTH), .WATERMARK(12)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .flush         (flush),
        .clear_overrun (clear_overrun),
        .m_data        (m_data),
        .m_parity_err  (m_parity_err),
        .m_frame_err   (m_frame_err),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .count         (count),
        .full          (full),
        .overrun       (overrun),
        .level_irq     (level_irq)
    );

    always #5 clk = ~clk;

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic fe, input int hold);
        @(negedge clk);
        rx_data = d; parity_err = pe; frame_err = fe; data_ready = 1'b1;
        repeat (hold) @(negedge clk);
        data_ready = 1'b0; parity_err = 1'b0; frame_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (count !== 5'd0)   begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
        n_checks++; if (full !== 1'b0 || overrun !== 1'b0 || level_irq !== 1'b0)
            begin n_errors++; $display("FAIL reset_flags: got full=%b ovr=%b irq=%b expected 0 0 0", full, overrun, level_irq); end
        n_checks++; if ({m_frame_err, m_parity_err, m_data} !== 10'd0)
            begin n_errors++; $display("FAIL reset_data: got %h expected 000", {m_frame_err, m_parity_err, m_data}); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        @(negedge clk);
        n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL single_pre_valid: got %b expected 0", m_valid); end
        rx_data = 8'hA5; data_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (m_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid_latency: got %b expected 1", m_valid); end
        n_checks++; if (m_data !== 8'hA5) begin n_errors++; $display("FAIL single_data: got %h expected a5", m_data); end
        repeat (15) @(negedge clk);
        data_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (count !== 5'd1) begin n_errors++; $display("FAIL single_count: got %0d expected 1", count); end
        pop_one();
        n_checks++; if (count !== 5'd0 || m_valid !== 1'b0)
            begin n_errors++; $display("FAIL single_drain: got count=%0d valid=%b expected 0 0", count, m_valid); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 1; i <= 16; i++) send_frame(8'(i), 1'b0, 1'b0, 2);
        n_checks++; if (full !== 1'b1 || count !== 5'd16)
            begin n_errors++; $display("FAIL fill_full: got full=%b count=%0d expected 1 16", full, count); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL fill_no_ovr: got %b expected 0", overrun); end
        send_frame(8'h55, 1'b0, 1'b0, 3);
        n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        n_checks++; if (count !== 5'd16 || m_data !== 8'h01)
            begin n_errors++; $display("FAIL ovr_untouched: got count=%0d head=%h expected 16 01", count, m_data); end
        for (int i = 1; i <= 16; i++) begin
            n_checks++; if (m_valid !== 1'b1 || m_data !== 8'(i))
                begin n_errors++; $display("FAIL drain_%0d: got valid=%b data=%h expected 1 %h", i, m_valid, m_data, 8'(i)); end
            pop_one();
        end
        n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL drain_empty: got %b expected 0", m_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        clear_overrun = 1'b1; @(negedge clk); clear_overrun = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_error_flags();
        logic [9:0] exp [3];
        exp[0] = 10'b01_0001_0001;
        exp[1] = 10'b10_0010_0010;
        exp[2] = 10'b00_0011_0011;
        send_frame(8'h11, 1'b1, 1'b0, 2);
        send_frame(8'h22, 1'b0, 1'b1, 2);
        send_frame(8'h33, 1'b0, 1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({m_frame_err, m_parity_err, m_data} !== exp[i])
                begin n_errors++; $display("FAIL err_entry_%0d: got %b expected %b", i, {m_frame_err, m_parity_err, m_data}, exp[i]); end
            pop_one();
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b0, 2);
        @(negedge clk);
        rx_data = 8'hEE; data_ready = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0; data_ready = 1'b0;
        n_checks++; if (count !== 5'd16 || overrun !== 1'b0)
            begin n_errors++; $display("FAIL pp_full: got count=%0d ovr=%b expected 16 0", count, overrun); end
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] e;
            e = (i == 16) ? 8'hEE : 8'h20 + 8'(i);
            n_checks++; if (m_data !== e)
                begin n_errors++; $display("FAIL pp_drain_%0d: got %h expected %h", i, m_data, e); end
            pop_one();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) send_frame(8'h90 + 8'(i), 1'b0, 1'b0, 2);
        @(negedge clk);
        flush = 1'b1; rx_data = 8'h99; data_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (count !== 5'd0 || m_valid !== 1'b0 || overrun !== 1'b0)
            begin n_errors++; $display("FAIL flush_clear: got count=%0d valid=%b ovr=%b expected 0 0 0", count, m_valid, overrun); end
        repeat (2) @(negedge clk);
        data_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL flush_no_recapture: got %0d expected 0", count); end
        send_frame(8'h3C, 1'b0, 1'b0, 2);
        n_checks++; if (m_data !== 8'h3C || count !== 5'd1)
            begin n_errors++; $display("FAIL flush_next_head: got data=%h count=%0d expected 3c 1", m_data, count); end
        pop_one();
    endtask

    task automatic test_watermark();
        logic exp_hi;
`ifdef UART_RX_FIFO_WATERMARK_EN
        exp_hi = 1'b1;
`else
        exp_hi = 1'b0;
`endif
        for (int i = 0; i < 11; i++) send_frame(8'(i), 1'b0, 1'b0, 2);
        n_checks++; if (level_irq !== 1'b0) begin n_errors++; $display("FAIL wm_11: got %b expected 0", level_irq); end
        send_frame(8'hB0, 1'b0, 1'b0, 2);
        n_checks++; if (level_irq !== exp_hi) begin n_errors++; $display("FAIL wm_12: got %b expected %b", level_irq, exp_hi); end
        pop_one();
        n_checks++; if (level_irq !== 1'b0) begin n_errors++; $display("FAIL wm_pop: got %b expected 0", level_irq); end
        do_flush();
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 3; i++) send_frame(8'h70 + 8'(i), 1'b0, 1'b0, 2);
        #1 resetn = 1'b0;
        #1;
        n_checks++; if (count !== 5'd0 || m_valid !== 1'b0 || m_data !== 8'h00)
            begin n_errors++; $display("FAIL midop_reset: got count=%0d valid=%b data=%h expected 0 0 00", count, m_valid, m_data); end
        @(negedge clk); resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_fill_overrun();
        test_error_flags();
        test_full_push_pop();
        test_flush();
        test_watermark();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
